extended_hamming_stream_checker: RTL
====================================

// Module: extended_hamming_stream_checker
// PURPOSE
//  Streaming, multi-lane extended-Hamming checker: accepts LANES blocks per beat over valid/ready,
//  flags per-lane correctable / uncorrectable errors one cycle later alongside the untouched blocks,
//  keeps saturating error counters and logs the first error seen. Sits on memory read / link RX paths.
// PARAMETERS
//  BLOCK_WIDTH    8   width of one extended-Hamming block (data + parity); DATA/PARITY widths derived
//  LANES          4   blocks checked per beat
//  COUNTER_WIDTH  16  width of each saturating error counter
// PORTS
//  clock                      in   1                   clock
//  reset                      in   1                   asynchronous active-high reset
//  in_valid                   in   1                   input beat valid
//  in_ready                   out  1                   input beat accepted when in_valid & in_ready
//  in_blocks                  in   LANES*BLOCK_WIDTH   lane i = in_blocks[i*BLOCK_WIDTH +: BLOCK_WIDTH]
//  out_valid                  out  1                   output beat valid
//  out_ready                  in   1                   downstream accepts output beat
//  out_blocks                 out  LANES*BLOCK_WIDTH   registered copy of accepted blocks, unmodified
//  out_correctable            out  LANES               per-lane single-bit (correctable) error flag
//  out_uncorrectable          out  LANES               per-lane double-bit (uncorrectable) error flag
//  clear_counters             in   1                   synchronous clear of counters and first-error log
//  correctable_count          out  COUNTER_WIDTH       saturating count of correctable lane errors
//  uncorrectable_count        out  COUNTER_WIDTH       saturating count of uncorrectable lane errors
//  first_error_valid          out  1                   first-error log holds an entry
//  first_error_lane           out  max(1,$clog2(LANES)) lane index of logged error
//  first_error_uncorrectable  out  1                   logged error was uncorrectable
//  first_error_block          out  BLOCK_WIDTH         raw erroneous block as received
// BEHAVIOUR
//  - Reset (async assert, sync deassert by system): every output register -> 0; in_ready then reads 1.
//  - Per lane: correctable = extra-parity syndrome set; uncorrectable = Hamming syndrome non-zero AND
//    extra-parity syndrome clear. The two flags are mutually exclusive by construction.
//  - Single output register stage, latency 1 cycle. in_ready = !out_valid | out_ready (combinational).
//  - Accept (in_valid & in_ready): out_blocks/out_* flags load, out_valid <= 1. No accept while
//    out_ready: out_valid <= 0. Stall (out_valid & !out_ready): all out_* held stable; no counter change.
//  - Full-throughput: back-to-back beats with out_ready=1 continuously, one beat per cycle.
//  - Counters update only on accept: cnt <= min(cnt + popcount(flags), 2^COUNTER_WIDTH-1); sum
//    computed COUNTER_WIDTH+$clog2(LANES+1) wide, then clamped. Saturated counter stays saturated.
//  - clear_counters: counters <= 0, first_error_valid <= 0. Same cycle as accept: counters <= that
//    beat's popcount (clear then add); log captures that beat's error if any.
//  - First-error log: on accept with any flag set while log empty (or clearing), capture the lowest-index
//    erroneous lane, its type and raw block; first_error_valid <= 1. Held until clear or reset.
//  - Reset mid-stream: in-flight output beat discarded, counters and log lost; no partial state survives.
//  - clear_counters does not affect the data path or handshake.
// STRUCTURE
//  - Width macros from the shared extended_hamming header; no new package types needed.
//  - Sub-module: one extended_hamming_block_checker per lane (generate loop), combinational, ahead
//    of the output register. Popcount, saturating add and priority lane encoder inline.
// TESTING
//  - Reset: hold reset 3 cycles -> out_valid=0, in_ready=1, both counts 0, first_error_valid=0.
//  - Clean stream: 100 beats of valid codewords (e.g. all lanes 8'h00), out_ready=1 -> 100 outputs,
//    1-cycle latency, flags 0, counts 0, out_blocks == in_blocks.
//  - Mixed errors: lane 2 single-bit flip, lane 1 two data bits flipped, one beat -> out_correctable=4'b0100,
//    out_uncorrectable=4'b0010, counts 1/1, log lane=1, uncorrectable=1, block=flipped lane-1 value.
//  - Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, counts unchanged;
//    release -> beats delivered in order, none lost or duplicated.
//  - Saturation: COUNTER_WIDTH=4, 5 beats with 4 correctable lanes each -> correctable_count stops at 15.
//  - Clear+error same cycle: counts 7, clear_counters with 2 correctable lanes accepted -> count 2,
//    log re-captured with lowest erroneous lane.

Source files
------------

// File: rtl/extended_hamming_stream_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module : extended_hamming_stream_checker_pkg
//  Brief  : Shared width helpers for the extended-Hamming stream checker.
//  Rev    : 1.0  initial release
// ============================================================================
package extended_hamming_stream_checker_pkg;

  // Hamming syndrome width for a block whose top bit is the overall parity
  // and whose remaining bits sit at Hamming positions 1 .. BLOCK_WIDTH-1.
  function automatic int syndrome_width(input int block_width);
    return (block_width > 2) ? $clog2(block_width) : 1;
  endfunction

  // Width of a lane index; never narrower than one bit.
  function automatic int lane_index_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/extended_hamming_stream_checker_block_checker.sv
`default_nettype none
// ============================================================================
//  Module : extended_hamming_stream_checker_block_checker
//  Brief  : Combinational extended-Hamming check of one block. Bit p-1 holds
//           Hamming position p (1 .. BLOCK_WIDTH-1); the MSB is the overall
//           parity bit covering the whole block (even parity).
//  Rev    : 1.0  initial release
// ============================================================================
module extended_hamming_stream_checker_block_checker
  import extended_hamming_stream_checker_pkg::*;
#(
  parameter int BLOCK_WIDTH = 8
) (
  input  logic [BLOCK_WIDTH-1:0] block,
  output logic                   correctable,
  output logic                   uncorrectable
);

  localparam int SYN_W = syndrome_width(BLOCK_WIDTH);

  logic [SYN_W-1:0] syndrome;
  logic             overall_parity;

  // Syndrome is the XOR of the positions of all set bits; overall parity
  // decides between a single (odd) and a double (even, non-zero) error.
  always_comb begin
    syndrome = '0;
    for (int p = 1; p < BLOCK_WIDTH; p++) begin
      if (block[p-1]) begin
        syndrome = syndrome ^ SYN_W'(p);
      end
    end
    overall_parity = ^block;
    correctable    = overall_parity;
    uncorrectable  = (syndrome != '0) && !overall_parity;
  end

endmodule
`default_nettype wire

// File: rtl/extended_hamming_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module : extended_hamming_stream_checker
//  Brief  : Multi-lane extended-Hamming stream checker. One register stage:
//           blocks pass through untouched with per-lane error flags, plus
//           saturating error counters and a first-error log.
//  Rev    : 1.0  initial release
// ============================================================================
module extended_hamming_stream_checker
  import extended_hamming_stream_checker_pkg::*;
#(
  parameter int BLOCK_WIDTH   = 8,
  parameter int LANES         = 4,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*BLOCK_WIDTH-1:0]         in_blocks,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES*BLOCK_WIDTH-1:0]         out_blocks,
  output logic [LANES-1:0]                     out_correctable,
  output logic [LANES-1:0]                     out_uncorrectable,
  input  logic                                 clear_counters,
  output logic [COUNTER_WIDTH-1:0]             correctable_count,
  output logic [COUNTER_WIDTH-1:0]             uncorrectable_count,
  output logic                                 first_error_valid,
  output logic [lane_index_width(LANES)-1:0]   first_error_lane,
  output logic                                 first_error_uncorrectable,
  output logic [BLOCK_WIDTH-1:0]               first_error_block
);

  localparam int LANE_W = lane_index_width(LANES);
  localparam int POP_W  = $clog2(LANES + 1);
  localparam int SUM_W  = COUNTER_WIDTH + POP_W;
  localparam logic [SUM_W-1:0] COUNT_MAX = SUM_W'({COUNTER_WIDTH{1'b1}});

  logic [LANES-1:0]         lane_correctable;
  logic [LANES-1:0]         lane_uncorrectable;
  logic [LANES-1:0]         lane_error;
  logic                     accept;
  logic                     any_error;
  logic [POP_W-1:0]         corr_pop;
  logic [POP_W-1:0]         unc_pop;
  logic [SUM_W-1:0]         corr_sum;
  logic [SUM_W-1:0]         unc_sum;
  logic [COUNTER_WIDTH-1:0] corr_next;
  logic [COUNTER_WIDTH-1:0] unc_next;
  logic [LANE_W-1:0]        error_lane;
  logic                     error_lane_uncorrectable;
  logic [BLOCK_WIDTH-1:0]   error_block;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      extended_hamming_stream_checker_block_checker #(
        .BLOCK_WIDTH (BLOCK_WIDTH)
      ) u_block_checker (
        .block         (in_blocks[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
        .correctable   (lane_correctable[i]),
        .uncorrectable (lane_uncorrectable[i])
      );
    end
  endgenerate

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign lane_error = lane_correctable | lane_uncorrectable;
  assign any_error  = |lane_error;

  // Per-beat error popcounts added to the (optionally cleared) counters, then clamped.
  always_comb begin
    corr_pop = '0;
    unc_pop  = '0;
    for (int i = 0; i < LANES; i++) begin
      corr_pop = corr_pop + POP_W'(lane_correctable[i]);
      unc_pop  = unc_pop + POP_W'(lane_uncorrectable[i]);
    end
    corr_sum  = (clear_counters ? '0 : SUM_W'(correctable_count)) + SUM_W'(corr_pop);
    unc_sum   = (clear_counters ? '0 : SUM_W'(uncorrectable_count)) + SUM_W'(unc_pop);
    corr_next = (corr_sum > COUNT_MAX) ? {COUNTER_WIDTH{1'b1}} : corr_sum[COUNTER_WIDTH-1:0];
    unc_next  = (unc_sum > COUNT_MAX) ? {COUNTER_WIDTH{1'b1}} : unc_sum[COUNTER_WIDTH-1:0];
  end

  // Lowest-index erroneous lane, its error type and its raw block.
  always_comb begin
    error_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_error[i]) begin
        error_lane = LANE_W'(i);
      end
    end
    error_lane_uncorrectable = lane_uncorrectable[error_lane];
    error_block              = in_blocks[error_lane*BLOCK_WIDTH +: BLOCK_WIDTH];
  end

  // Output register stage: load on accept, drop valid once consumed, hold on stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_blocks        <= '0;
      out_correctable   <= '0;
      out_uncorrectable <= '0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_blocks        <= in_blocks;
      out_correctable   <= lane_correctable;
      out_uncorrectable <= lane_uncorrectable;
    end else if (out_ready) begin
      out_valid         <= 1'b0;
    end
  end

  // Saturating counters: change only on accept, or zero on a clear without accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      correctable_count   <= '0;
      uncorrectable_count <= '0;
    end else if (accept) begin
      correctable_count   <= corr_next;
      uncorrectable_count <= unc_next;
    end else if (clear_counters) begin
      correctable_count   <= '0;
      uncorrectable_count <= '0;
    end
  end

  // First-error log: a clear empties it, and a same-cycle erroneous beat refills it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_error_valid         <= 1'b0;
      first_error_lane          <= '0;
      first_error_uncorrectable <= 1'b0;
      first_error_block         <= '0;
    end else begin
      if (clear_counters) begin
        first_error_valid <= 1'b0;
      end
      if (accept && any_error && (!first_error_valid || clear_counters)) begin
        first_error_valid         <= 1'b1;
        first_error_lane          <= error_lane;
        first_error_uncorrectable <= error_lane_uncorrectable;
        first_error_block         <= error_block;
      end
    end
  end

endmodule
`default_nettype wire
